// File: rtl/rounded_avg_decoder.sv
// rounded_avg_decoder: sums windows of 2^K accepted rounded codes to recover
// K extra bits of resolution; the window sum is the average with K fractional bits.
module rounded_avg_decoder #(
    parameter int unsigned W = 3,
    parameter int unsigned K = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [W+K-1:0]   out_data,
    input  logic             out_ready,
    output logic             odd_err
);

    localparam int unsigned SW   = W + K;
    localparam int unsigned N    = 1 << K;
    localparam logic [K-1:0] LAST = K'(N - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   acc;
    logic [SW-1:0]   acc_nxt;
    logic [K-1:0]    cnt;
    logic [K-1:0]    cnt_nxt;
    logic            out_valid_nxt;
    logic [SW-1:0]   out_data_nxt;
    logic            odd_err_nxt;
    logic            in_acc;
    logic            out_acc;
    logic [SW-1:0]   sum;

    // In HOLD a new sample may only enter in the cycle the held result drains
    always_comb begin
        in_ready = (state == ACCUM) ? 1'b1 : out_ready;
    end

    // Handshake qualifiers and running window sum (max N*(2^W-1) fits SW bits)
    always_comb begin
        in_acc  = in_valid & in_ready;
        out_acc = out_valid & out_ready;
        sum     = acc + SW'(in_data);
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        odd_err_nxt   = odd_err;

        if (in_acc && in_data[0]) begin
            odd_err_nxt = 1'b1;
        end

        case (state)
            ACCUM: begin
                if (in_acc) begin
                    if (cnt == LAST) begin
                        out_data_nxt  = sum;
                        acc_nxt       = '0;
                        cnt_nxt       = '0;
                        out_valid_nxt = 1'b1;
                        state_nxt     = HOLD;
                    end else begin
                        acc_nxt = sum;
                        cnt_nxt = cnt + K'(1);
                    end
                end
            end
            HOLD: begin
                if (out_acc) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = ACCUM;
                    // Draining cycle doubles as the first sample of the next window
                    if (in_acc) begin
                        acc_nxt = SW'(in_data);
                        cnt_nxt = K'(1);
                    end
                end
            end
            default: begin
                state_nxt     = ACCUM;
                out_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            odd_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            odd_err   <= odd_err_nxt;
        end
    end

endmodule

// File: tb/tb_rounded_avg_decoder.sv
// Testbench for rounded_avg_decoder (W=3, K=2): table-driven vectors plus
// hand-written backpressure and reset sequences.
module tb_rounded_avg_decoder;

    localparam int unsigned W = 3;
    localparam int unsigned K = 2;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_ready;
    logic           out_valid;
    logic [W+K-1:0] out_data;
    logic           out_ready;
    logic           odd_err;

    int checks;
    int errors;

    typedef struct {
        logic           v;
        logic [W-1:0]   d;
        logic           r;
        logic           ir;
        logic           ov;
        logic [W+K-1:0] od;
        logic           err;
    } vec_t;

    vec_t tbl[$];

    rounded_avg_decoder #(.W(W), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .odd_err   (odd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input int d, input logic r, input logic ir,
                       input logic ov, input int od, input logic err);
        vec_t e;
        e.v   = v;
        e.d   = W'(d);
        e.r   = r;
        e.ir  = ir;
        e.ov  = ov;
        e.od  = (W+K)'(od);
        e.err = err;
        tbl.push_back(e);
    endtask

    // Drive one cycle at negedge, check in_ready before the edge, outputs after
    task automatic step(input string tag, input logic v, input int d, input logic r,
                        input logic ir, input logic ov, input int od, input logic err);
        @(negedge clk);
        in_valid  = v;
        in_data   = W'(d);
        out_ready = r;
        #1;
        chk({tag, " in_ready"}, int'(in_ready), int'(ir));
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, int'(out_valid), int'(ov));
        chk({tag, " out_data"}, int'(out_data), od);
        chk({tag, " odd_err"}, int'(odd_err), int'(err));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Window 2,4,6,6 -> 18 (4.50)
        add(1, 2, 1, 1, 0, 0, 0);
        add(1, 4, 1, 1, 0, 0, 0);
        add(1, 6, 1, 1, 0, 0, 0);
        add(1, 6, 1, 1, 1, 18, 0);
        add(0, 0, 1, 1, 0, 18, 0);
        // Back-to-back windows with drain overlapping next window
        add(1, 6, 1, 1, 0, 18, 0);
        add(1, 6, 1, 1, 0, 18, 0);
        add(1, 6, 1, 1, 0, 18, 0);
        add(1, 6, 1, 1, 1, 24, 0);
        add(1, 4, 1, 1, 0, 24, 0);
        add(1, 4, 1, 1, 0, 24, 0);
        add(1, 4, 1, 1, 0, 24, 0);
        add(1, 4, 1, 1, 1, 16, 0);
        add(0, 0, 1, 1, 0, 16, 0);
        // Full-scale odd codes, then sticky odd_err across a zero window
        add(1, 7, 1, 1, 0, 16, 1);
        add(1, 7, 1, 1, 0, 16, 1);
        add(1, 7, 1, 1, 0, 16, 1);
        add(1, 7, 1, 1, 1, 28, 1);
        add(1, 0, 1, 1, 0, 28, 1);
        add(1, 0, 1, 1, 0, 28, 1);
        add(1, 0, 1, 1, 0, 28, 1);
        add(1, 0, 1, 1, 1, 0, 1);
        add(0, 0, 1, 1, 0, 0, 1);

        // Reset state is visible while rst is held
        #2;
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_data", int'(out_data), 0);
        chk("reset odd_err", int'(odd_err), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("row%0d", i), tbl[i].v, int'(tbl[i].d), tbl[i].r,
                 tbl[i].ir, tbl[i].ov, int'(tbl[i].od), tbl[i].err);
        end

        // Backpressure: result held, input blocked, then drain + accept together
        do_reset();
        step("bp w0", 1, 2, 1, 1, 0, 0, 0);
        step("bp w1", 1, 2, 1, 1, 0, 0, 0);
        step("bp w2", 1, 2, 1, 1, 0, 0, 0);
        step("bp w3", 1, 2, 1, 1, 1, 8, 0);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("bp hold%0d", i), 1, 4, 0, 0, 1, 8, 0);
        end
        step("bp drain", 1, 4, 1, 1, 0, 8, 0);
        // acc=4, cnt=1: three more 4s complete the window at 16
        step("bp n1", 1, 4, 1, 1, 0, 8, 0);
        step("bp n2", 1, 4, 1, 1, 0, 8, 0);
        step("bp n3", 1, 4, 1, 1, 1, 16, 0);

        // Reset mid-window discards the partial sum
        do_reset();
        step("mid a0", 1, 6, 1, 1, 0, 0, 0);
        step("mid a1", 1, 6, 1, 1, 0, 0, 0);
        do_reset();
        step("mid b0", 1, 2, 1, 1, 0, 0, 0);
        step("mid b1", 1, 2, 1, 1, 0, 0, 0);
        step("mid b2", 1, 2, 1, 1, 0, 0, 0);
        step("mid b3", 1, 2, 1, 1, 1, 8, 0);

        // Asynchronous reset while holding a result
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("hold pre-reset in_ready", int'(in_ready), 0);
        rst = 1'b1;
        #1;
        chk("async in_ready", int'(in_ready), 1);
        chk("async out_valid", int'(out_valid), 0);
        chk("async out_data", int'(out_data), 0);
        @(negedge clk);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
